// File: rtl/bcs_serial_compare_ctrl.sv
// Serial MSB-first comparator controller driving one external bit-comparator slice.
// Latches operands on start, walks one bit pair per cycle, reports A/B relation with a done pulse.
module bcs_serial_compare_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             b_gt_a,
  output logic             a_gt_b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_e,
  output logic             slice_g,
  input  logic             slice_e1,
  input  logic             slice_g1
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               e_q, e_d;
  logic               g_q, g_d;
  logic               eq_q, eq_d;
  logic               bgt_q, bgt_d;
  logic               agt_q, agt_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      e_q     <= 1'b1;
      g_q     <= 1'b0;
      eq_q    <= 1'b0;
      bgt_q   <= 1'b0;
      agt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      e_q     <= e_d;
      g_q     <= g_d;
      eq_q    <= eq_d;
      bgt_q   <= bgt_d;
      agt_q   <= agt_d;
    end
  end

  // Next-state, cascade feedback and result load
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    idx_d   = idx_q;
    e_d     = e_q;
    g_d     = g_q;
    eq_d    = eq_q;
    bgt_d   = bgt_q;
    agt_d   = agt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          e_d     = 1'b1;
          g_d     = 1'b0;
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        e_d = slice_e1;
        g_d = slice_g1;
        if ((idx_q == '0) || (EARLY_EXIT && !slice_e1)) begin
          eq_d    = slice_e1;
          bgt_d   = slice_g1;
          agt_d   = ~slice_e1 & ~slice_g1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slice bit pair is only presented while a compare is running
  always_comb begin
    slice_a = 1'b0;
    slice_b = 1'b0;
    if (state_q == S_RUN) begin
      slice_a = a_sh_q[idx_q];
      slice_b = b_sh_q[idx_q];
    end
  end

  assign slice_e = e_q;
  assign slice_g = g_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign a_eq_b  = eq_q;
  assign b_gt_a  = bgt_q;
  assign a_gt_b  = agt_q;

endmodule

// File: tb/tb_bcs_serial_compare_ctrl.sv
// Directed and random bench for bcs_serial_compare_ctrl with a behavioural slice model.
// Two instances share stimulus: one with early exit, one running the full width.
module tb_bcs_serial_compare_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;

  logic busy1, done1, eq1, bgt1, agt1, sa1, sb1, se1, sg1, e1_1, g1_1;
  logic busy0, done0, eq0, bgt0, agt0, sa0, sb0, se0, sg0, e1_0, g1_0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Bit-comparator slice model
  assign e1_1 = se1 & ~(sa1 ^ sb1);
  assign g1_1 = sg1 | (se1 & sb1 & ~sa1);
  assign e1_0 = se0 & ~(sa0 ^ sb0);
  assign g1_0 = sg0 | (se0 & sb0 & ~sa0);

  bcs_serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .a_eq_b(eq1), .b_gt_a(bgt1), .a_gt_b(agt1),
    .slice_a(sa1), .slice_b(sb1), .slice_e(se1), .slice_g(sg1),
    .slice_e1(e1_1), .slice_g1(g1_1)
  );

  bcs_serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .a_eq_b(eq0), .b_gt_a(bgt0), .a_gt_b(agt0),
    .slice_a(sa0), .slice_b(sb0), .slice_e(se0), .slice_g(sg0),
    .slice_e1(e1_0), .slice_g1(g1_0)
  );

  function automatic int exp_t(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
    if (ee) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (a[i] != b[i]) return W - i;
      end
    end
    return W;
  endfunction

  // {a_eq_b, b_gt_a, a_gt_b}
  function automatic logic [2:0] exp_f(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (ia == ib) return 3'b100;
    if (ib > ia)  return 3'b010;
    return 3'b001;
  endfunction

  // Launch one compare and record the done edge index and flags of each instance
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int t1, output int t0,
                         output logic [2:0] f1, output logic [2:0] f0);
    t1 = -1; t0 = -1; f1 = 3'b000; f0 = 3'b000;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (done1 && t1 < 0) begin t1 = k; f1 = {eq1, bgt1, agt1}; end
      if (done0 && t0 < 0) begin t0 = k; f0 = {eq0, bgt0, agt0}; end
      if (t1 >= 0 && t0 >= 0) break;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy1, done1, eq1, bgt1, agt1} !== 5'b0) $display("FAIL reset_status got %b want 00000", {busy1, done1, eq1, bgt1, agt1});
    else pass_cnt++;
    total_cnt++;
    if ({sa1, sb1, se1, sg1} !== 4'b0010) $display("FAIL reset_slice got %b want 0010", {sa1, sb1, se1, sg1});
    else pass_cnt++;
    total_cnt++;
    if ({busy0, done0, eq0, bgt0, agt0, sa0, sb0, se0, sg0} !== 9'b000000010) $display("FAIL reset_full got %b want 000000010", {busy0, done0, eq0, bgt0, agt0, sa0, sb0, se0, sg0});
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midrun;
    int t1, t0;
    logic [2:0] f1, f0;
    logic saw_done;
    run_cmp(8'h13, 8'h12, t1, t0, f1, f0);
    total_cnt++;
    if (f1 !== 3'b001) $display("FAIL pre_reset_result got %b want 001", f1);
    else pass_cnt++;
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h3C; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({busy1, busy0} !== 2'b11) $display("FAIL midrun_busy got %b want 11", {busy1, busy0});
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy1, done1, eq1, bgt1, agt1, busy0, done0, eq0, bgt0, agt0} !== 10'b0)
      $display("FAIL midrun_reset got %b want 0000000000", {busy1, done1, eq1, bgt1, agt1, busy0, done0, eq0, bgt0, agt0});
    else pass_cnt++;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done1 | done0;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | done1 | done0 | busy1 | busy0;
    end
    total_cnt++;
    if (saw_done !== 1'b0) $display("FAIL midrun_no_done got %b want 0", saw_done);
    else pass_cnt++;
  endtask

  task automatic test_equal;
    int t1, t0;
    logic [2:0] f1, f0;
    run_cmp(8'hA5, 8'hA5, t1, t0, f1, f0);
    total_cnt++;
    if (t1 !== 8 || f1 !== 3'b100) $display("FAIL equal_ee got t=%0d f=%b want t=8 f=100", t1, f1);
    else pass_cnt++;
    total_cnt++;
    if (t0 !== 8 || f0 !== 3'b100) $display("FAIL equal_full got t=%0d f=%b want t=8 f=100", t0, f0);
    else pass_cnt++;
    run_cmp(8'hFF, 8'hFF, t1, t0, f1, f0);
    total_cnt++;
    if (t1 !== 8 || f1 !== 3'b100) $display("FAIL equal_ff got t=%0d f=%b want t=8 f=100", t1, f1);
    else pass_cnt++;
  endtask

  task automatic test_early_exit;
    int t1, t0;
    logic [2:0] f1, f0;
    run_cmp(8'h80, 8'h7F, t1, t0, f1, f0);
    total_cnt++;
    if (t1 !== 1 || f1 !== 3'b001) $display("FAIL early_exit got t=%0d f=%b want t=1 f=001", t1, f1);
    else pass_cnt++;
    total_cnt++;
    if (t0 !== 8 || f0 !== 3'b001) $display("FAIL no_early_exit got t=%0d f=%b want t=8 f=001", t0, f0);
    else pass_cnt++;
    run_cmp(8'h50, 8'h58, t1, t0, f1, f0);
    total_cnt++;
    if (t1 !== 5 || f1 !== 3'b010) $display("FAIL early_exit_mid got t=%0d f=%b want t=5 f=010", t1, f1);
    else pass_cnt++;
  endtask

  task automatic test_lsb_diff;
    logic [W-1:0] seq_a, seq_b;
    logic all_busy;
    seq_a = '0; seq_b = '0; all_busy = 1'b1;
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h13; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      seq_a = {seq_a[W-2:0], sa1};
      seq_b = {seq_b[W-2:0], sb1};
      all_busy = all_busy & busy1 & ~done1;
      @(posedge clk);
    end
    @(negedge clk);
    total_cnt++;
    if (seq_a !== 8'h12 || seq_b !== 8'h13) $display("FAIL lsb_slice_seq got a=%h b=%h want a=12 b=13", seq_a, seq_b);
    else pass_cnt++;
    total_cnt++;
    if (all_busy !== 1'b1) $display("FAIL lsb_busy got %b want 1", all_busy);
    else pass_cnt++;
    total_cnt++;
    if ({done1, busy1, eq1, bgt1, agt1} !== 5'b10010) $display("FAIL lsb_result got %b want 10010", {done1, busy1, eq1, bgt1, agt1});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done1, busy1, eq1, bgt1, agt1} !== 5'b00010) $display("FAIL lsb_hold got %b want 00010", {done1, busy1, eq1, bgt1, agt1});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic stable;
    int t0;
    @(negedge clk);
    a_in = 8'h13; b_in = 8'h12; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = (k == 2);
      if (k == 2) begin a_in = 8'h55; b_in = 8'hAA; end
      @(posedge clk);
    end
    @(negedge clk);
    total_cnt++;
    if ({done1, eq1, bgt1, agt1} !== 4'b1001) $display("FAIL ignored_start got %b want 1001", {done1, eq1, bgt1, agt1});
    else pass_cnt++;
    a_in = 8'h00; b_in = 8'hFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({busy1, done1, eq1, bgt1, agt1} !== 5'b10001) $display("FAIL b2b_restart got %b want 10001", {busy1, done1, eq1, bgt1, agt1});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy1, done1, eq1, bgt1, agt1} !== 5'b01010) $display("FAIL b2b_result got %b want 01010", {busy1, done1, eq1, bgt1, agt1});
    else pass_cnt++;
    stable = 1'b1; t0 = -1;
    for (int k = 10; k <= 40; k++) begin
      if (done0) begin t0 = k; break; end
      stable = stable & busy0 & ({eq0, bgt0, agt0} == 3'b001);
      @(negedge clk);
    end
    total_cnt++;
    if (stable !== 1'b1) $display("FAIL b2b_full_hold got %b want 1", stable);
    else pass_cnt++;
    total_cnt++;
    if (t0 !== 17 || {eq0, bgt0, agt0} !== 3'b010) $display("FAIL b2b_full_done got t=%0d f=%b want t=17 f=010", t0, {eq0, bgt0, agt0});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random;
    int t1, t0;
    logic [2:0] f1, f0, fe;
    logic [W-1:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom);
      b = (n % 8 == 0) ? a : W'($urandom);
      if (n % 8 == 1) b = a ^ W'(1 << $urandom_range(W - 1, 0));
      fe = exp_f(a, b);
      run_cmp(a, b, t1, t0, f1, f0);
      total_cnt++;
      if (!$onehot(f1)) $display("FAIL rnd_onehot a=%h b=%h got %b want one-hot", a, b, f1);
      else pass_cnt++;
      total_cnt++;
      if (f1 !== fe || t1 !== exp_t(a, b, 1'b1))
        $display("FAIL rnd_ee a=%h b=%h got t=%0d f=%b want t=%0d f=%b", a, b, t1, f1, exp_t(a, b, 1'b1), fe);
      else pass_cnt++;
      total_cnt++;
      if (f0 !== fe || t0 !== exp_t(a, b, 1'b0))
        $display("FAIL rnd_full a=%h b=%h got t=%0d f=%b want t=%0d f=%b", a, b, t0, f0, exp_t(a, b, 1'b0), fe);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_equal();
    test_early_exit();
    test_lsb_diff();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcs_serial_compare_ctrl.md
# bcs_serial_compare_ctrl

Sequencing controller that reuses a single bit-comparator slice (BCS) to compare two WIDTH-bit unsigned operands serially, MSB first, one bit per clock. It latches the operands on a start request and presents one bit pair per cycle plus the registered equal/greater cascade to an external BCS instance. It feeds the slice's e1/g1 back into its cascade registers and reports the final relation with a one-cycle done pulse. The block sits between a requester and one slice instance, so an N-bit comparator costs one slice instead of N.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..32.
- EARLY_EXIT, 1: 1 = finish as soon as the cascade shows inequality; 0 = always run WIDTH bit cycles.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a_in  input  WIDTH  operand A; latched when start is accepted.
- b_in  input  WIDTH  operand B; latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results are valid in that cycle.
- a_eq_b  output  1  result: A == B.
- b_gt_a  output  1  result: B > A.
- a_gt_b  output  1  result: A > B.
- slice_a  output  1  bit of A to BCS input a1.
- slice_b  output  1  bit of B to BCS input b1.
- slice_e  output  1  cascade to BCS input e0.
- slice_g  output  1  cascade to BCS input g0.
- slice_e1  input  1  BCS output e1.
- slice_g1  input  1  BCS output g1.

## Operation
- Slice function, which the verification model must use: e1 = e0 & ~(a1 ^ b1); g1 = g0 | (e0 & b1 & ~a1). The g output means "B greater than A".
- Registers: a_sh and b_sh (each WIDTH bits), idx (clog2(WIDTH) bits), e_reg, g_reg, state, and the three result flags.
- States are IDLE, RUN and DONE.
- IDLE or DONE with start = 1:
  - latch a_sh = a_in and b_sh = b_in;
  - set e_reg = 1, g_reg = 0, idx = WIDTH-1;
  - go to RUN.
- IDLE with start = 0: stay in IDLE.
- DONE with start = 0: go to IDLE.
- RUN, combinational slice drive: slice_a = a_sh[idx], slice_b = b_sh[idx], slice_e = e_reg, slice_g = g_reg.
- RUN, at each edge:
  - e_reg <= slice_e1 and g_reg <= slice_g1;
  - if idx == 0, or if EARLY_EXIT = 1 and slice_e1 = 0, go to DONE and load the results;
  - otherwise decrement idx.
- Result load when entering DONE:
  - a_eq_b = slice_e1;
  - b_gt_a = slice_g1;
  - a_gt_b = ~slice_e1 & ~slice_g1.
- Outside RUN: slice_a = slice_b = 0, slice_e = e_reg, slice_g = g_reg.
- Results hold their values through DONE and IDLE and change only at the next result load.
- Exactly one result flag is high after any completed compare.
- start asserted during RUN is ignored; the operation in flight is not disturbed.
- Reset mid-operation aborts immediately. No done pulse is produced and the results are cleared.

## Timing
- Reset values:
  - state = IDLE, busy = 0, done = 0;
  - a_eq_b = b_gt_a = a_gt_b = 0;
  - e_reg = 1, g_reg = 0, idx = 0, a_sh = b_sh = 0;
  - all slice_* outputs are 0 except slice_e = 1.
- busy = (state == RUN) and done = (state == DONE). Both are decoded from the state register, so they are glitch-free relative to clk.
- Start accepted at edge 0: RUN from edge 0 until the terminating edge T.
  - Without early exit, T = WIDTH.
  - With EARLY_EXIT = 1, T = (WIDTH - p), where p is the position of the first differing bit counting from the MSB (MSB = position WIDTH-1).
  - done is high for exactly the cycle between edges T and T+1.
- Back-to-back: start held high during DONE is accepted at edge T+1. Throughput is one compare per T+1 cycles.
- The BCS is a purely combinational path of one slice delay from slice_* to slice_e1/slice_g1, and it must settle within one clk period.

## Test plan
- Reset mid-run: WIDTH = 8, start with A = 0x3C, B = 0x3C, deassert rst_n at edge 4 -> busy = 0 and all results 0 immediately; no done pulse.
- Equal operands: A = 0xA5, B = 0xA5, EARLY_EXIT = 1 -> done at edge 8, a_eq_b = 1, b_gt_a = 0, a_gt_b = 0.
- Early exit on the MSB: A = 0x80, B = 0x7F -> done at edge 1 (one bit cycle), a_gt_b = 1.
  - Same operands with EARLY_EXIT = 0 -> done at edge 8 with the same result.
- LSB difference: A = 0x12, B = 0x13 -> done at edge 8 with b_gt_a = 1.
  - slice_a/slice_b must show bits 7 down to 0 of each operand in order, one bit per cycle.
- Ignored start and back-to-back: pulse start at edge 3 during RUN -> no effect.
  - Hold start high in DONE with A = 0x00, B = 0xFF -> new RUN begins at the next edge; done one cycle later with b_gt_a = 1.
  - The previous results must stay stable until that second load.
- Randomised: 1000 random operand pairs against an integer compare model -> exactly one result flag is high after each compare, and it matches the model.
